add_fft_arb: RTL and testbench
==============================

ADD_FFT_ARB -- requirements
Module: add_fft_arb

Interface
REQ-001 SHALL have parameter DIN_W, default 256, meaning width of one FFT input vector in bits.
REQ-002 SHALL have parameter AW, default 8, meaning result RAM address width.
REQ-003 SHALL have parameter DW, default 8, meaning result RAM data width.
REQ-004 SHALL have parameter NPTS, default 256, meaning expected result writes per FFT run.
REQ-005 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  2  per-requester FFT request, level.
- din0_i  in  DIN_W  requester 0 input vector.
- din1_i  in  DIN_W  requester 1 input vector.
- gnt_o  out  2  one-hot grant, registered.
- done_o  out  2  per-requester completion, 1-cycle pulse.
- ram0_wr_o  out  1  write strobe to requester 0 result RAM.
- ram1_wr_o  out  1  write strobe to requester 1 result RAM.
- ram_addr_o  out  AW  shared result address, passed from FFT.
- ram_din_o  out  DW  shared result data, passed from FFT.
- err_o  out  1  sticky protocol error flag.
- fft_start_o  out  1  start pulse to the shared additive FFT.
- fft_din_o  out  DIN_W  registered input vector to the FFT.
- fft_done_i  in  1  FFT completion pulse.
- fft_ram_wr_i  in  1  FFT result write strobe.
- fft_ram_addr_i  in  AW  FFT result address.
- fft_ram_din_i  in  DW  FFT result data.

Function
REQ-006 SHALL implement FSM IDLE -> START -> RUN -> FIN -> IDLE.
REQ-007 IDLE: if any req_i bit set, SHALL select winner, set gnt_o one-hot, load fft_din_o from winner's din, clear write counter, enter START next cycle.
REQ-008 Arbitration SHALL be round-robin: both requesting -> requester indicated by priority pointer wins; single requester wins unconditionally.
REQ-009 Priority pointer SHALL be 0 after reset and SHALL point to the non-winner after each FIN.
REQ-010 START: fft_start_o SHALL be 1 for exactly this one cycle; next state RUN.
REQ-011 RUN: fft_ram_wr_i SHALL be steered combinationally to ram0_wr_o or ram1_wr_o per gnt_o; the other strobe stays 0.
REQ-012 ram_addr_o and ram_din_o SHALL equal fft_ram_addr_i and fft_ram_din_i at all times, zero latency.
REQ-013 RUN: each fft_ram_wr_i SHALL increment a 9-bit write counter, saturating at 511.
REQ-014 RUN: fft_done_i SHALL cause transition to FIN; a write in the same cycle SHALL be steered and counted.
REQ-015 FIN: done_o[winner] SHALL pulse for one cycle; gnt_o SHALL clear at the end of the cycle; next state IDLE.
REQ-016 Latency: req_i rising in IDLE -> gnt_o at +1, fft_start_o at +1, done_o at one cycle after fft_done_i.
REQ-017 Back-to-back: a request pending in FIN SHALL be granted from the following IDLE cycle (minimum one idle cycle between runs).
REQ-018 fft_din_o SHALL hold its value from IDLE grant until the next grant; din changes during a run are ignored.
REQ-019 Dropping req_i during START/RUN SHALL NOT abort; the run completes and done_o still pulses.
REQ-020 err_o SHALL set when: write count != NPTS in FIN; fft_ram_wr_i in IDLE/START/FIN (write dropped, no RAM strobe); fft_done_i in IDLE/START (ignored).
REQ-021 err_o SHALL stay set until reset.

Reset
REQ-022 rst_ni low at a clock edge SHALL force state IDLE, pointer 0, counter 0, err_o 0, gnt_o 0, done_o 0, fft_start_o 0, fft_din_o 0, including mid-run.
REQ-023 ram0_wr_o and ram1_wr_o SHALL be 0 while in IDLE after reset.

Structure
REQ-024 Package add_fft_pkg SHALL hold the FSM state encoding and constant NPTS_DEF=256.
REQ-025 Block SHALL be flat; the 2-way round-robin pick SHALL be inline logic, no sub-module.

Verification
REQ-026 Single request: req_i=01, FFT model issues 256 writes then done -> gnt_o=01, ram0_wr_o pulses 256 times, done_o=01 for 1 cycle, err_o=0.
REQ-027 Contention: req_i=11 from reset -> requester 0 runs first; then requester 1 runs; din1_i sampled at its grant.
REQ-028 Fairness: req_i held at 11 for 4 runs -> grant order 0,1,0,1.
REQ-029 Short run: done after 255 writes -> done_o pulses, err_o=1 and stays 1.
REQ-030 Stray write: fft_ram_wr_i in IDLE -> no RAM strobe, err_o=1.
REQ-031 Reset mid-RUN at write 100 -> next cycle all outputs 0, state IDLE; a new req_i=10 grants requester 1 normally.

Source files
------------

// File: rtl/add_fft_pkg.sv
// Shared definitions for the additive-FFT arbiter: FSM encoding and the
// default number of result writes expected per FFT run.
package add_fft_pkg;

  localparam int NPTS_DEF = 256;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/add_fft_arb.sv
// Two-requester round-robin arbiter in front of one shared additive FFT.
// It grants one requester, starts the FFT, routes the result writes to that requester's RAM, and reports protocol errors.
module add_fft_arb
  import add_fft_pkg::*;
#(
  parameter int DIN_W = 256,
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int NPTS  = NPTS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_i,
  input  logic [DIN_W-1:0] din0_i,
  input  logic [DIN_W-1:0] din1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic             ram0_wr_o,
  output logic             ram1_wr_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [DW-1:0]    ram_din_o,
  output logic             err_o,
  output logic             fft_start_o,
  output logic [DIN_W-1:0] fft_din_o,
  input  logic             fft_done_i,
  input  logic             fft_ram_wr_i,
  input  logic [AW-1:0]    fft_ram_addr_i,
  input  logic [DW-1:0]    fft_ram_din_i
);

  localparam logic [8:0] NPTS_C  = 9'(NPTS);
  localparam logic [8:0] CNT_MAX = 9'h1ff;

  state_e           state_q, state_d;
  logic             ptr_q;
  logic [1:0]       gnt_q;
  logic [DIN_W-1:0] din_q;
  logic [8:0]       cnt_q;
  logic             err_q;
  logic             win;
  logic             in_run;
  logic             err_set;

  // Contention goes to the pointer; a lone requester wins outright.
  assign win = req_i[0] ? (req_i[1] & ptr_q) : 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; without it the combinational block would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_i) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (fft_done_i) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_run = (state_q == S_RUN);

  // Writes and done pulses are only legal while running; anything else is
  // dropped here and flagged.
  assign err_set = ((state_q == S_FIN) && (cnt_q != NPTS_C))
                 || (fft_ram_wr_i && !in_run)
                 || (fft_done_i && ((state_q == S_IDLE) || (state_q == S_START)));

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
      gnt_q <= 2'b00;
      din_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            gnt_q <= win ? 2'b10 : 2'b01;
            din_q <= win ? din1_i : din0_i;
            cnt_q <= '0;
          end
        end
        S_RUN: begin
          if (fft_ram_wr_i && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 9'd1;
        end
        S_FIN: begin
          gnt_q <= 2'b00;
          ptr_q <= gnt_q[0];
        end
        default: ;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = (state_q == S_FIN) ? gnt_q : 2'b00;
  assign fft_start_o = (state_q == S_START);
  assign fft_din_o   = din_q;
  assign err_o       = err_q;
  assign ram0_wr_o   = in_run & fft_ram_wr_i & gnt_q[0];
  assign ram1_wr_o   = in_run & fft_ram_wr_i & gnt_q[1];
  assign ram_addr_o  = fft_ram_addr_i;
  assign ram_din_o   = fft_ram_din_i;

endmodule

// File: tb/tb_add_fft_arb.sv
// Randomised bench for add_fft_arb: a transaction-level reference model
// (owner, age-in-run, write count) is compared with the DUT on every cycle.
module tb_add_fft_arb;

  localparam int DIN_W = 256;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int NPTS  = 256;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [1:0]       req_i = '0;
  logic [DIN_W-1:0] din0_i = '0;
  logic [DIN_W-1:0] din1_i = '0;
  logic [1:0]       gnt_o;
  logic [1:0]       done_o;
  logic             ram0_wr_o;
  logic             ram1_wr_o;
  logic [AW-1:0]    ram_addr_o;
  logic [DW-1:0]    ram_din_o;
  logic             err_o;
  logic             fft_start_o;
  logic [DIN_W-1:0] fft_din_o;
  logic             fft_done_i = 1'b0;
  logic             fft_ram_wr_i = 1'b0;
  logic [AW-1:0]    fft_ram_addr_i = '0;
  logic [DW-1:0]    fft_ram_din_i = '0;

  add_fft_arb #(.DIN_W(DIN_W), .AW(AW), .DW(DW), .NPTS(NPTS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .din0_i(din0_i), .din1_i(din1_i),
    .gnt_o(gnt_o), .done_o(done_o), .ram0_wr_o(ram0_wr_o), .ram1_wr_o(ram1_wr_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .err_o(err_o),
    .fft_start_o(fft_start_o), .fft_din_o(fft_din_o), .fft_done_i(fft_done_i),
    .fft_ram_wr_i(fft_ram_wr_i), .fft_ram_addr_i(fft_ram_addr_i),
    .fft_ram_din_i(fft_ram_din_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DIN_W-1:0] act,
                       input logic [DIN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner is -1 when nobody holds the FFT, age 0 is the
  // start cycle, fin marks the completion cycle.
  int               m_owner = -1;
  int               m_age   = 0;
  bit               m_fin   = 1'b0;
  bit               m_ptr   = 1'b0;
  int               m_cnt   = 0;
  bit               m_err   = 1'b0;
  logic [DIN_W-1:0] m_din   = '0;
  bit               m_valid = 1'b0;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_valid = 1'b1; m_owner = -1; m_age = 0; m_fin = 1'b0;
      m_ptr = 1'b0; m_cnt = 0; m_err = 1'b0; m_din = '0;
    end else if (m_owner < 0) begin
      if (fft_ram_wr_i || fft_done_i) m_err = 1'b1;
      if (req_i != 2'b00) begin
        if (req_i == 2'b11) m_owner = m_ptr ? 1 : 0;
        else                m_owner = req_i[0] ? 0 : 1;
        m_age = 0;
        m_cnt = 0;
        m_din = (m_owner == 1) ? din1_i : din0_i;
      end
    end else if (m_fin) begin
      if (m_cnt != NPTS || fft_ram_wr_i) m_err = 1'b1;
      m_ptr   = (m_owner == 0);
      m_owner = -1;
      m_fin   = 1'b0;
    end else if (m_age == 0) begin
      if (fft_ram_wr_i || fft_done_i) m_err = 1'b1;
      m_age = 1;
    end else begin
      if (fft_ram_wr_i && m_cnt < 511) m_cnt++;
      if (fft_done_i) m_fin = 1'b1;
    end
  end

  int         n_ram0 = 0;
  int         n_ram1 = 0;
  int         n_done = 0;
  logic [1:0] last_done = '0;
  logic [1:0] prev_gnt = '0;
  int         order[$];

  always @(negedge clk_i) begin
    logic [1:0] exp_gnt;
    bit         running;
    if (m_valid) begin
      exp_gnt = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      running = (m_owner >= 0) && (m_age >= 1) && !m_fin;
      check("gnt", DIN_W'(gnt_o), DIN_W'(exp_gnt));
      check("start", DIN_W'(fft_start_o), DIN_W'((m_owner >= 0) && (m_age == 0)));
      check("done", DIN_W'(done_o), DIN_W'(m_fin ? exp_gnt : 2'b00));
      check("ram0_wr", DIN_W'(ram0_wr_o), DIN_W'(running && fft_ram_wr_i && m_owner == 0));
      check("ram1_wr", DIN_W'(ram1_wr_o), DIN_W'(running && fft_ram_wr_i && m_owner == 1));
      check("ram_addr", DIN_W'(ram_addr_o), DIN_W'(fft_ram_addr_i));
      check("ram_din", DIN_W'(ram_din_o), DIN_W'(fft_ram_din_i));
      check("err", DIN_W'(err_o), DIN_W'(m_err));
      check("fft_din", fft_din_o, m_din);
    end
    if (ram0_wr_o) n_ram0++;
    if (ram1_wr_o) n_ram1++;
    if (done_o != 2'b00) begin n_done++; last_done = done_o; end
    if (gnt_o != 2'b00 && prev_gnt == 2'b00) order.push_back(gnt_o[1] ? 1 : 0);
    prev_gnt = gnt_o;
  end

  function automatic logic [DIN_W-1:0] rand_vec();
    logic [DIN_W-1:0] v;
    for (int k = 0; k < DIN_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    din0_i         = rand_vec();
    din1_i         = rand_vec();
    fft_ram_addr_i = AW'($urandom);
    fft_ram_din_i  = DW'($urandom);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_i = 2'b00; fft_ram_wr_i = 1'b0; fft_done_i = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  // Acts as the FFT: waits for the start pulse, issues nwr writes with
  // random gaps, then done (optionally in the same cycle as the last write).
  task automatic do_run(input int nwr, input bit done_with_last, input int abort_at,
                        input int gap_pct, input bit drop_req);
    bit started = 1'b0;
    for (int t = 0; t < 8 && !started; t++) begin
      if (fft_start_o) started = 1'b1;
      else tick();
    end
    check("start_seen", DIN_W'(started), DIN_W'(1'b1));
    if (!started) return;
    if (drop_req) req_i = 2'b00;
    tick();
    for (int i = 0; i < nwr; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        fft_ram_wr_i = 1'b0;
        tick();
      end
      if (i == abort_at) begin
        rst_ni = 1'b0; fft_ram_wr_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        return;
      end
      fft_ram_wr_i   = 1'b1;
      fft_ram_addr_i = AW'(i);
      if (i == nwr - 1 && done_with_last) fft_done_i = 1'b1;
      tick();
      fft_ram_wr_i = 1'b0;
      fft_done_i   = 1'b0;
    end
    if (!done_with_last || nwr == 0) begin
      fft_done_i = 1'b1;
      tick();
      fft_done_i = 1'b0;
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_gnt", DIN_W'(gnt_o), '0);
    check("rst_err", DIN_W'(err_o), '0);
    check("rst_start", DIN_W'(fft_start_o), '0);
    check("rst_fft_din", fft_din_o, '0);

    // Single requester 0, full 256-write run.
    n_ram0 = 0; n_ram1 = 0; n_done = 0;
    req_i = 2'b01;
    do_run(NPTS, 1'b1, -1, 20, 1'b1);
    check("s1_ram0_cnt", DIN_W'(n_ram0), DIN_W'(256));
    check("s1_ram1_cnt", DIN_W'(n_ram1), '0);
    check("s1_done_cnt", DIN_W'(n_done), DIN_W'(1));
    check("s1_done_val", DIN_W'(last_done), DIN_W'(2'b01));
    check("s1_err", DIN_W'(err_o), '0);

    // Contention held for four runs: strict alternation starting at 0.
    do_reset();
    order.delete();
    req_i = 2'b11;
    for (int r = 0; r < 4; r++) do_run(NPTS, r[0], -1, 5, 1'b0);
    req_i = 2'b00;
    check("s2_runs", DIN_W'(order.size()), DIN_W'(4));
    for (int r = 0; r < 4 && r < order.size(); r++)
      check("s2_order", DIN_W'(order[r]), DIN_W'(r % 2));
    check("s2_err", DIN_W'(err_o), '0);

    // Short run sets a sticky error.
    n_done = 0;
    req_i = 2'b01;
    do_run(NPTS - 1, 1'b0, -1, 0, 1'b1);
    check("s3_done_cnt", DIN_W'(n_done), DIN_W'(1));
    check("s3_err", DIN_W'(err_o), DIN_W'(1'b1));
    for (int k = 0; k < 5; k++) tick();
    check("s3_err_sticky", DIN_W'(err_o), DIN_W'(1'b1));

    // Stray write in IDLE: no strobe, error set.
    do_reset();
    check("s4_err_clr", DIN_W'(err_o), '0);
    fft_ram_wr_i = 1'b1;
    #2;
    check("s4_no_strobe", DIN_W'({ram1_wr_o, ram0_wr_o}), '0);
    tick();
    fft_ram_wr_i = 1'b0;
    check("s4_err", DIN_W'(err_o), DIN_W'(1'b1));

    // Reset mid-run at write 100, then requester 1 alone.
    do_reset();
    req_i = 2'b01;
    do_run(NPTS, 1'b1, 100, 0, 1'b1);
    check("s5_gnt", DIN_W'(gnt_o), '0);
    check("s5_done", DIN_W'(done_o), '0);
    check("s5_start", DIN_W'(fft_start_o), '0);
    check("s5_fft_din", fft_din_o, '0);
    check("s5_err", DIN_W'(err_o), '0);
    order.delete();
    req_i = 2'b10;
    do_run(NPTS, 1'b1, -1, 10, 1'b1);
    check("s5_winner", DIN_W'(order.size() > 0 ? order[0] : -1), DIN_W'(1));
    check("s5_err_after", DIN_W'(err_o), '0);

    // Random traffic: mixed requests, drops, lengths and stray pulses.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      int pick;
      pick = $urandom_range(9);
      if (pick == 0) begin
        fft_done_i = 1'b1; tick(); fft_done_i = 1'b0;
      end
      req_i = 2'($urandom_range(3, 1));
      pick = $urandom_range(9);
      do_run((pick < 7) ? NPTS : ((pick == 7) ? NPTS - 1 : NPTS + 1),
             1'($urandom), -1, $urandom_range(30), 1'($urandom));
      req_i = 2'b00;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
